enemy_map_updater: RTL
======================

Name: enemy_map_updater

Overview:
- Upstream writer for the 192-entry, 3-bit enemy occupancy tile map. The map is a 16x12 grid; code 0 means empty and codes 1..7 are enemy IDs.
- Serialises enemy-tank move requests. For each request it:
  - checks the target tile through the map's combinational read port;
  - clears the old tile and sets the new one, using the map's synchronous write port.
- Also provides a full-map clear sweep for level start.

Parameters:
- DATA_WIDTH, 3, tile code width (matches the map).
- ADDR_WIDTH, 15, map address width (matches the map).
- MAP_DEPTH, 192, number of valid tiles (addresses 0..191).

Ports:
- clk, input, 1: single clock. It also drives the map's write clock.
- rst_n, input, 1: asynchronous active-low reset.
- req_valid, input, 1: move request present.
- req_ready, output, 1: block can accept a request (high only in IDLE).
- req_id, input, DATA_WIDTH: enemy ID 1..7.
- req_cur, input, ADDR_WIDTH: tile the enemy currently occupies.
- req_tgt, input, ADDR_WIDTH: tile the enemy wants to move to.
- resp_valid, output, 1: one-cycle pulse when the request completes.
- resp_grant, output, 1: 1 = move committed, 0 = denied. Meaningful only while resp_valid is high.
- sweep_start, input, 1: start a clear of all tiles.
- sweep_done, output, 1: one-cycle pulse when the clear finishes.
- map_rd_addr, output, ADDR_WIDTH: to the map's combinational read port.
- map_rd_data, input, DATA_WIDTH: tile code returned from map_rd_addr, same cycle.
- map_we, output, 1: map write enable.
- map_wr_addr, output, ADDR_WIDTH: map write address.
- map_wr_data, output, DATA_WIDTH: map write data.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state goes to IDLE; all captured request registers and the sweep counter clear to 0;
  - req_ready=1, resp_valid=0, resp_grant=0, sweep_done=0, map_we=0;
  - map_rd_addr, map_wr_addr and map_wr_data are 0.
  - Reset mid-operation abandons the operation. Any map write already clocked in stays in the map.
- States: IDLE, CHECK, CLR_OLD, SET_NEW, RESP, SWEEP, SWEEP_DONE. All outputs are decoded from state and registers, with no combinational path from req_*.
- IDLE:
  - req_ready=1.
  - sweep_start=1 → SWEEP, counter=0. Sweep has priority if sweep_start and req_valid are both high; the request is not accepted.
  - Otherwise req_valid=1 → capture id, cur and tgt, then → CHECK.
- CHECK:
  - map_rd_addr = captured tgt; map_rd_data is sampled at the clock edge.
  - Deny (→ RESP with grant=0) if any of the following holds:
    - id == 0;
    - cur >= MAP_DEPTH;
    - tgt >= MAP_DEPTH;
    - map_rd_data is nonzero and not equal to id.
  - If tgt == cur and none of the deny conditions hold → RESP with grant=1 and no writes.
  - Otherwise → CLR_OLD.
- CLR_OLD: map_we=1, map_wr_addr=cur, map_wr_data=0 → SET_NEW.
- SET_NEW: map_we=1, map_wr_addr=tgt, map_wr_data=id → RESP with grant=1.
- RESP: resp_valid=1 and resp_grant=stored decision for exactly one cycle → IDLE.
- Latency from the accept edge to the start of the resp_valid cycle:
  - granted move: 4 cycles;
  - denied request or same-tile request: 2 cycles.
- SWEEP:
  - map_we=1, map_wr_addr=counter, map_wr_data=0 each cycle, counter increments.
  - When the counter reaches MAP_DEPTH-1 → SWEEP_DONE after that write. That is 192 writes, each address exactly once, with no write at or above MAP_DEPTH.
  - sweep_start and req_valid are ignored while in SWEEP.
- SWEEP_DONE: sweep_done=1 for one cycle → IDLE.
- map_we=0 in every state other than CLR_OLD, SET_NEW and SWEEP.
- Address comparisons are unsigned at full ADDR_WIDTH. The counter is 8 bits, zero-extended onto the address bus.

Decomposition:
- Shared package holds:
  - MAP_DEPTH = 192;
  - the tile code constant TILE_EMPTY = 0;
  - the state enumeration.
- No sub-module is needed. The FSM plus the sweep counter is a single module.

Test Plan:
- Reset, then sweep_start → exactly 192 writes of 0 to addresses 0..191 in order, then one sweep_done pulse, then req_ready=1.
- Map empty; req id=2, cur=10, tgt=11 → write addr 10 data 0, then write addr 11 data 2. resp_valid with grant=1 arrives 4 cycles after accept.
- Map[11]=3; req id=2, cur=10, tgt=11 → no map_we. resp_valid with grant=0 arrives 2 cycles after accept.
- Invalid requests, each → grant=0 with no writes:
  - req tgt=192;
  - req id=0;
  - req cur=200.
- Map[5]=4; req id=4, cur=5, tgt=5 → grant=1 with no writes.
- sweep_start and req_valid asserted in the same IDLE cycle → sweep runs and the request is not accepted. After sweep_done, the still-held request completes with grant=1.
- Assert rst_n=0 during SET_NEW → all outputs take reset values immediately and the state is IDLE. The next request is processed normally.

Source files
------------

// File: rtl/enemy_map_updater_pkg.sv
// Shared constants and FSM state encoding for the enemy occupancy map writer.
package enemy_map_updater_pkg;
   localparam int MAP_DEPTH  = 192;
   localparam int TILE_EMPTY = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_CLR_OLD,
      ST_SET_NEW,
      ST_RESP,
      ST_SWEEP,
      ST_SWEEP_DONE
   } state_t;
endpackage

// File: rtl/enemy_map_updater.sv
// Serialises enemy-tank moves into the 16x12 tile map and runs the level-start clear sweep.
module enemy_map_updater #(
   parameter int DATA_WIDTH = 3,
   parameter int ADDR_WIDTH = 15,
   parameter int MAP_DEPTH  = enemy_map_updater_pkg::MAP_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [DATA_WIDTH-1:0] req_id,
   input  logic [ADDR_WIDTH-1:0] req_cur,
   input  logic [ADDR_WIDTH-1:0] req_tgt,
   output logic                  resp_valid,
   output logic                  resp_grant,
   input  logic                  sweep_start,
   output logic                  sweep_done,
   output logic [ADDR_WIDTH-1:0] map_rd_addr,
   input  logic [DATA_WIDTH-1:0] map_rd_data,
   output logic                  map_we,
   output logic [ADDR_WIDTH-1:0] map_wr_addr,
   output logic [DATA_WIDTH-1:0] map_wr_data
);
   import enemy_map_updater_pkg::*;

   localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(MAP_DEPTH);
   localparam logic [7:0]            CNT_LAST = 8'(MAP_DEPTH - 1);
   localparam logic [DATA_WIDTH-1:0] EMPTY    = DATA_WIDTH'(TILE_EMPTY);

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_id;
   logic [ADDR_WIDTH-1:0] r_cur;
   logic [ADDR_WIDTH-1:0] r_tgt;
   logic [7:0]            r_cnt;
   logic                  r_ready;
   logic                  r_resp_valid;
   logic                  r_grant;
   logic                  r_sweep_done;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_wr_addr;
   logic [DATA_WIDTH-1:0] r_wr_data;

   logic                  w_deny;
   logic                  w_same;
   logic [7:0]            w_cnt_nxt;

   // Target is blocked only by a different enemy; its own ID there is not a collision.
   always_comb begin
      w_deny    = (r_id == EMPTY) || (r_cur >= DEPTH_A) || (r_tgt >= DEPTH_A) ||
                  ((map_rd_data != EMPTY) && (map_rd_data != r_id));
      w_same    = (r_tgt == r_cur);
      w_cnt_nxt = r_cnt + 8'd1;
   end

   // Outputs are flops loaded with the values the next state presents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_id         <= '0;
         r_cur        <= '0;
         r_tgt        <= '0;
         r_cnt        <= '0;
         r_ready      <= 1'b1;
         r_resp_valid <= 1'b0;
         r_grant      <= 1'b0;
         r_sweep_done <= 1'b0;
         r_we         <= 1'b0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
      end else begin
         r_ready      <= 1'b0;
         r_resp_valid <= 1'b0;
         r_grant      <= 1'b0;
         r_sweep_done <= 1'b0;
         r_we         <= 1'b0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
         case (r_state)
            ST_IDLE: begin
               if (sweep_start) begin
                  r_state <= ST_SWEEP;
                  r_cnt   <= '0;
                  r_we    <= 1'b1;
               end else if (req_valid) begin
                  r_state <= ST_CHECK;
                  r_id    <= req_id;
                  r_cur   <= req_cur;
                  r_tgt   <= req_tgt;
               end else begin
                  r_ready <= 1'b1;
               end
            end
            ST_CHECK: begin
               if (w_deny || w_same) begin
                  r_state      <= ST_RESP;
                  r_resp_valid <= 1'b1;
                  r_grant      <= !w_deny;
               end else begin
                  r_state   <= ST_CLR_OLD;
                  r_we      <= 1'b1;
                  r_wr_addr <= r_cur;
               end
            end
            ST_CLR_OLD: begin
               r_state   <= ST_SET_NEW;
               r_we      <= 1'b1;
               r_wr_addr <= r_tgt;
               r_wr_data <= r_id;
            end
            ST_SET_NEW: begin
               r_state      <= ST_RESP;
               r_resp_valid <= 1'b1;
               r_grant      <= 1'b1;
            end
            ST_RESP: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b1;
            end
            ST_SWEEP: begin
               if (r_cnt == CNT_LAST) begin
                  r_state      <= ST_SWEEP_DONE;
                  r_sweep_done <= 1'b1;
               end else begin
                  r_cnt     <= w_cnt_nxt;
                  r_we      <= 1'b1;
                  r_wr_addr <= ADDR_WIDTH'(w_cnt_nxt);
               end
            end
            ST_SWEEP_DONE: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b1;
            end
            default: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign req_ready   = r_ready;
   assign resp_valid  = r_resp_valid;
   assign resp_grant  = r_grant;
   assign sweep_done  = r_sweep_done;
   assign map_rd_addr = r_tgt;
   assign map_we      = r_we;
   assign map_wr_addr = r_wr_addr;
   assign map_wr_data = r_wr_data;

endmodule
